race_ctrl: RTL and testbench
============================

RACE_CTRL -- requirements
Module: race_ctrl

Interface
REQ-001 The block SHALL have parameter N_PLAYERS, default 2, giving the number of racers (range 1-8).
REQ-002 The block SHALL have parameter POS_W, default 32, giving the width of each position counter.
REQ-003 The block SHALL have parameter SPD_W, default 4, giving the width of each speed value.
REQ-004 The block SHALL have parameter MAX_SPEED, default 15, giving the speed ceiling; it SHALL be no greater than 2^SPD_W-1.
REQ-005 The block SHALL have parameter FINISH, default 4096, giving the finish position; it SHALL be less than 2^POS_W.
REQ-006 The block SHALL have parameter TICK_DIV, default 6500000, giving the clk cycles per game tick (10 Hz at 65 MHz).
REQ-007 The block SHALL have parameter CD_STEPS, default 3, giving the countdown length in ticks (1-7).
REQ-008 Port clk, input, 1 bit: single clock, clk65MHz domain.
REQ-009 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 Port start, input, 1 bit: single-cycle request to begin a race.
REQ-011 Port gas, input, N_PLAYERS bits: per-player throttle level, already synchronised to clk.
REQ-012 Port tick, output, 1 bit: one-cycle pulse on each game tick.
REQ-013 Port state, output, 2 bits: 0 IDLE, 1 COUNTDOWN, 2 RACE, 3 FINISHED.
REQ-014 Port lights, output, 3 bits: remaining countdown value.
REQ-015 Port pos, output, N_PLAYERS*POS_W bits: positions; player i occupies bits [i*POS_W +: POS_W].
REQ-016 Port speed, output, N_PLAYERS*SPD_W bits: speeds, packed the same way as pos.
REQ-017 Port false_start, output, N_PLAYERS bits: sticky per-player disqualification flags.
REQ-018 Port winner, output, 3 bits: index of the winning player.
REQ-019 Port winner_valid, output, 1 bit: winner is meaningful.
REQ-020 Port tie, output, 1 bit: more than one player finished on the winning tick.

Function
REQ-021 A free-running counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be 1 in the cycle the counter equals TICK_DIV-1; the counter is independent of FSM state.
REQ-022 In IDLE, start=1 SHALL enter COUNTDOWN on the next cycle with lights=CD_STEPS; pos, speed, false_start, winner, winner_valid and tie SHALL be cleared on that same transition.
REQ-023 In COUNTDOWN, each tick SHALL decrement lights; the tick that takes lights from 1 to 0 SHALL enter RACE.
REQ-024 In COUNTDOWN, gas[i]=1 in any cycle SHALL set false_start[i], which then holds until the next race start or reset.
REQ-025 In RACE, on each tick, for every player without false_start: gas[i]=1 -> speed+1 saturating at MAX_SPEED, else speed-1 saturating at 0; then pos += new speed, zero-extended, saturating at FINISH.
REQ-026 Disqualified players SHALL keep speed=0 and pos=0 throughout RACE.
REQ-027 Pos and speed SHALL change only on tick cycles; gas is sampled only in the tick cycle.
REQ-028 On the tick at which one or more players' updated pos equals FINISH, the next state SHALL be FINISHED, with winner = lowest such index, winner_valid=1, and tie=1 if more than one player reached FINISH on that tick.
REQ-029 If all players have false_start set on entry to RACE, the next cycle SHALL be FINISHED with winner_valid=0.
REQ-030 FINISHED SHALL hold all outputs; start=1 SHALL behave as in REQ-022.
REQ-031 start SHALL be ignored in COUNTDOWN and RACE.
REQ-032 All outputs except tick SHALL be registered; tick SHALL be a registered pulse.

Reset
REQ-033 reset=1 at a clock edge SHALL, in any state, force state=IDLE, lights=0, pos=0, speed=0, false_start=0, winner=0, winner_valid=0, tie=0, tick=0, and the tick counter to 0.
REQ-034 Reset SHALL take priority over start and tick in the same cycle.

Verification
All scenarios use N_PLAYERS=2, TICK_DIV=4, FINISH=20, MAX_SPEED=3, CD_STEPS=3.
REQ-035 Reset for 2 cycles -> all outputs 0, state=0; tick first asserts 4 cycles after reset is released.
REQ-036 start pulse, gas=0 -> lights reads 3, then 2, 1, 0 at successive ticks; state=2 after the third tick; pos stays 0.
REQ-037 gas=01 held through RACE -> speed0 goes 1,2,3,3,...; pos0 goes 1,3,6,9,12,15,18,20; state=3, winner=0, winner_valid=1, tie=0; pos1=0.
REQ-038 gas=11 held through RACE -> both players reach pos 20 on the same tick; winner=0, tie=1.
REQ-039 gas[1]=1 during COUNTDOWN, then gas=11 in RACE -> false_start=10, pos1 stays 0, winner=0; a second start pulse clears false_start.
REQ-040 reset asserted mid-RACE with pos0=9 -> next cycle all outputs 0 and state=0; a start pulse asserted during RACE (without reset) -> no change to state or lights.

Source files
------------

// File: rtl/race_ctrl.sv
// Multi-player race game controller: tick divider, countdown with false-start
// detection, per-tick speed/position update and winner/tie resolution.
module race_ctrl #(
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned POS_W     = 32,
    parameter int unsigned SPD_W     = 4,
    parameter int unsigned MAX_SPEED = 15,
    parameter int unsigned FINISH    = 4096,
    parameter int unsigned TICK_DIV  = 6500000,
    parameter int unsigned CD_STEPS  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [N_PLAYERS-1:0]         gas,
    output logic                         tick,
    output logic [1:0]                   state,
    output logic [2:0]                   lights,
    output logic [N_PLAYERS*POS_W-1:0]   pos,
    output logic [N_PLAYERS*SPD_W-1:0]   speed,
    output logic [N_PLAYERS-1:0]         false_start,
    output logic [2:0]                   winner,
    output logic                         winner_valid,
    output logic                         tie
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SUM_W = POS_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SPD_W-1:0] MAX_SPD  = SPD_W'(MAX_SPEED);
    localparam logic [POS_W-1:0] FIN_POS  = POS_W'(FINISH);
    localparam logic [2:0]       CD_INIT  = 3'(CD_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CD    = 2'd1,
        ST_RACE  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       tick_q, tick_d;
    state_t                     state_q, state_d;
    logic [2:0]                 lights_q, lights_d;
    logic [N_PLAYERS*POS_W-1:0] pos_q, pos_d;
    logic [N_PLAYERS*SPD_W-1:0] spd_q, spd_d;
    logic [N_PLAYERS-1:0]       fs_q, fs_d;
    logic [2:0]                 winner_q, winner_d;
    logic                       wv_q, wv_d;
    logic                       tie_q, tie_d;

    logic [SPD_W-1:0]           spd_cur [N_PLAYERS];
    logic [SPD_W-1:0]           spd_nx  [N_PLAYERS];
    logic [SUM_W-1:0]           sum_nx  [N_PLAYERS];
    logic [POS_W-1:0]           pos_nx  [N_PLAYERS];
    logic [N_PLAYERS-1:0]       fin_hit;

    // Free-running tick divider; tick is registered so it lines up with cnt_q == last.
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    // Candidate per-player speed/position for the next tick.
    always_comb begin
        fin_hit = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            spd_cur[i] = spd_q[i*SPD_W +: SPD_W];
            if (gas[i]) begin
                spd_nx[i] = (spd_cur[i] < MAX_SPD) ? spd_cur[i] + SPD_W'(1) : MAX_SPD;
            end else begin
                spd_nx[i] = (spd_cur[i] != '0) ? spd_cur[i] - SPD_W'(1) : '0;
            end
            sum_nx[i] = {1'b0, pos_q[i*POS_W +: POS_W]} + SUM_W'(spd_nx[i]);
            pos_nx[i] = (sum_nx[i] >= {1'b0, FIN_POS}) ? FIN_POS : sum_nx[i][POS_W-1:0];
            fin_hit[i] = !fs_q[i] && (pos_nx[i] == FIN_POS);
        end
    end

    always_comb begin
        state_d  = state_q;
        lights_d = lights_q;
        pos_d    = pos_q;
        spd_d    = spd_q;
        fs_d     = fs_q;
        winner_d = winner_q;
        wv_d     = wv_q;
        tie_d    = tie_q;
        unique case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    state_d  = ST_CD;
                    lights_d = CD_INIT;
                    pos_d    = '0;
                    spd_d    = '0;
                    fs_d     = '0;
                    winner_d = '0;
                    wv_d     = 1'b0;
                    tie_d    = 1'b0;
                end
            end
            ST_CD: begin
                fs_d = fs_q | gas;
                if (tick_q) begin
                    lights_d = lights_q - 3'd1;
                    if (lights_q == 3'd1) begin
                        state_d = ST_RACE;
                    end
                end
            end
            ST_RACE: begin
                // Nobody eligible: end the race without a winner.
                if (&fs_q) begin
                    state_d = ST_FIN;
                end else if (tick_q) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (!fs_q[i]) begin
                            spd_d[i*SPD_W +: SPD_W] = spd_nx[i];
                            pos_d[i*POS_W +: POS_W] = pos_nx[i];
                        end
                    end
                    if (|fin_hit) begin
                        state_d = ST_FIN;
                        wv_d    = 1'b1;
                        tie_d   = ($countones(fin_hit) > 1);
                        for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
                            if (fin_hit[i]) begin
                                winner_d = 3'(i);
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lights_q <= '0;
            pos_q    <= '0;
            spd_q    <= '0;
            fs_q     <= '0;
            winner_q <= '0;
            wv_q     <= 1'b0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lights_q <= lights_d;
            pos_q    <= pos_d;
            spd_q    <= spd_d;
            fs_q     <= fs_d;
            winner_q <= winner_d;
            wv_q     <= wv_d;
            tie_q    <= tie_d;
        end
    end

    assign tick         = tick_q;
    assign state        = state_q;
    assign lights       = lights_q;
    assign pos          = pos_q;
    assign speed        = spd_q;
    assign false_start  = fs_q;
    assign winner       = winner_q;
    assign winner_valid = wv_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_race_ctrl.sv
// Scoreboard bench for race_ctrl: a game-level reference model predicts every
// cycle's outputs; a monitor compares them against the DUT.
module tb_race_ctrl;

    localparam int NP        = 2;
    localparam int POS_W     = 32;
    localparam int SPD_W     = 4;
    localparam int MAX_SPEED = 3;
    localparam int FINISH    = 20;
    localparam int TICK_DIV  = 4;
    localparam int CD_STEPS  = 3;

    typedef struct packed {
        logic                    tick;
        logic [1:0]              state;
        logic [2:0]              lights;
        logic [NP*POS_W-1:0]     pos;
        logic [NP*SPD_W-1:0]     speed;
        logic [NP-1:0]           fs;
        logic [2:0]              winner;
        logic                    wv;
        logic                    tie;
    } snap_t;

    logic                clk;
    logic                reset;
    logic                start;
    logic [NP-1:0]       gas;
    logic                tick;
    logic [1:0]          state;
    logic [2:0]          lights;
    logic [NP*POS_W-1:0] pos;
    logic [NP*SPD_W-1:0] speed;
    logic [NP-1:0]       false_start;
    logic [2:0]          winner;
    logic                winner_valid;
    logic                tie;

    int errors = 0;
    int checks = 0;
    snap_t exp_q[$];

    // Reference model of the game, in plain integers.
    int m_state, m_lights, m_winner, m_cyc;
    bit m_wv, m_tie, m_tick;
    int m_pos [NP];
    int m_spd [NP];
    bit m_fs  [NP];

    race_ctrl #(
        .N_PLAYERS(NP), .POS_W(POS_W), .SPD_W(SPD_W), .MAX_SPEED(MAX_SPEED),
        .FINISH(FINISH), .TICK_DIV(TICK_DIV), .CD_STEPS(CD_STEPS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .gas(gas),
        .tick(tick), .state(state), .lights(lights), .pos(pos), .speed(speed),
        .false_start(false_start), .winner(winner), .winner_valid(winner_valid),
        .tie(tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        m_lights = 0; m_winner = 0; m_wv = 0; m_tie = 0;
        for (int i = 0; i < NP; i++) begin
            m_pos[i] = 0; m_spd[i] = 0; m_fs[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic r, input logic s, input logic [NP-1:0] g);
        bit tick_now;
        bit all_dq;
        int hits, first;
        if (r) begin
            model_clear();
            m_state = 0; m_cyc = 0; m_tick = 0;
            return;
        end
        tick_now = m_tick;
        m_cyc  = (m_cyc + 1) % TICK_DIV;
        m_tick = (m_cyc == TICK_DIV - 1);
        case (m_state)
            0, 3: begin
                if (s) begin
                    model_clear();
                    m_state = 1; m_lights = CD_STEPS;
                end
            end
            1: begin
                for (int i = 0; i < NP; i++) if (g[i]) m_fs[i] = 1;
                if (tick_now) begin
                    m_lights = m_lights - 1;
                    if (m_lights == 0) m_state = 2;
                end
            end
            default: begin
                all_dq = 1;
                for (int i = 0; i < NP; i++) if (!m_fs[i]) all_dq = 0;
                if (all_dq) begin
                    m_state = 3;
                end else if (tick_now) begin
                    hits = 0; first = 0;
                    for (int i = 0; i < NP; i++) begin
                        if (!m_fs[i]) begin
                            if (g[i]) m_spd[i] = (m_spd[i] < MAX_SPEED) ? m_spd[i] + 1 : MAX_SPEED;
                            else      m_spd[i] = (m_spd[i] > 0) ? m_spd[i] - 1 : 0;
                            m_pos[i] = (m_pos[i] + m_spd[i] > FINISH) ? FINISH : m_pos[i] + m_spd[i];
                            if (m_pos[i] == FINISH) begin
                                if (hits == 0) first = i;
                                hits++;
                            end
                        end
                    end
                    if (hits > 0) begin
                        m_state = 3; m_winner = first; m_wv = 1; m_tie = (hits > 1);
                    end
                end
            end
        endcase
    endfunction

    function automatic snap_t model_snap();
        snap_t sn;
        sn.tick   = m_tick;
        sn.state  = 2'(m_state);
        sn.lights = 3'(m_lights);
        for (int i = 0; i < NP; i++) begin
            sn.pos[i*POS_W +: POS_W]   = POS_W'(m_pos[i]);
            sn.speed[i*SPD_W +: SPD_W] = SPD_W'(m_spd[i]);
            sn.fs[i]                   = m_fs[i];
        end
        sn.winner = 3'(m_winner);
        sn.wv     = m_wv;
        sn.tie    = m_tie;
        return sn;
    endfunction

    task automatic drive(input logic r, input logic s, input logic [NP-1:0] g);
        reset = r; start = s; gas = g;
        model_step(r, s, g);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_until(input int st, input logic [NP-1:0] g, input int budget, input string name);
        int n;
        n = 0;
        while (state !== 2'(st) && n < budget) begin
            drive(1'b0, 1'b0, g);
            n++;
        end
        check(name, 64'(state), 64'(st));
    endtask

    // Monitor: every cycle's registered outputs against the queued prediction.
    initial begin
        snap_t act, exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act.tick = tick; act.state = state; act.lights = lights;
                act.pos = pos; act.speed = speed; act.fs = false_start;
                act.winner = winner; act.wv = winner_valid; act.tie = tie;
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL snapshot t=%0t got tk=%b st=%0d li=%0d pos=%h spd=%h fs=%b w=%0d wv=%b tie=%b exp tk=%b st=%0d li=%0d pos=%h spd=%h fs=%b w=%0d wv=%b tie=%b",
                             $time, act.tick, act.state, act.lights, act.pos, act.speed, act.fs,
                             act.winner, act.wv, act.tie, exp.tick, exp.state, exp.lights,
                             exp.pos, exp.speed, exp.fs, exp.winner, exp.wv, exp.tie);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic r, s;
        logic [NP-1:0] g;
        m_state = 0; m_cyc = 0; m_tick = 0;
        model_clear();

        // Reset, then idle long enough to see the first ticks.
        drive(1'b1, 1'b0, 2'b00);
        drive(1'b1, 1'b0, 2'b00);
        check("reset_state", 64'(state), 64'd0);
        check("reset_pos", 64'(pos), 64'd0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 2'b00);

        // Solo race with player 0 on the throttle.
        drive(1'b0, 1'b1, 2'b00);
        check("start_lights", 64'(lights), 64'd3);
        check("start_state", 64'(state), 64'd1);
        run_until(2, 2'b00, 40, "cd_to_race");
        check("race_lights", 64'(lights), 64'd0);
        drive(1'b0, 1'b0, 2'b01);
        drive(1'b0, 1'b1, 2'b01);
        check("start_ignored_state", 64'(state), 64'd2);
        run_until(3, 2'b01, 80, "solo_finish");
        check("solo_pos0", 64'(pos[POS_W-1:0]), 64'd20);
        check("solo_pos1", 64'(pos[2*POS_W-1:POS_W]), 64'd0);
        check("solo_winner", 64'(winner), 64'd0);
        check("solo_wv", 64'(winner_valid), 64'd1);
        check("solo_tie", 64'(tie), 64'd0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 2'b10);

        // Dead heat from FINISHED.
        drive(1'b0, 1'b1, 2'b00);
        run_until(2, 2'b00, 40, "tie_cd");
        run_until(3, 2'b11, 80, "tie_finish");
        check("tie_flag", 64'(tie), 64'd1);
        check("tie_winner", 64'(winner), 64'd0);
        check("tie_pos1", 64'(pos[2*POS_W-1:POS_W]), 64'd20);

        // Player 1 jumps the start.
        drive(1'b0, 1'b1, 2'b00);
        run_until(2, 2'b10, 40, "fs_cd");
        run_until(3, 2'b11, 80, "fs_finish");
        check("fs_flags", 64'(false_start), 64'b10);
        check("fs_pos1", 64'(pos[2*POS_W-1:POS_W]), 64'd0);
        check("fs_winner", 64'(winner), 64'd0);
        drive(1'b0, 1'b1, 2'b00);
        check("fs_cleared", 64'(false_start), 64'd0);

        // Everyone jumps the start: race ends with no winner.
        run_until(2, 2'b11, 40, "alldq_cd");
        run_until(3, 2'b00, 4, "alldq_finish");
        check("alldq_wv", 64'(winner_valid), 64'd0);

        // Reset in the middle of a race.
        drive(1'b0, 1'b1, 2'b00);
        run_until(2, 2'b00, 40, "rst_cd");
        n = 0;
        while (pos[POS_W-1:0] !== 32'd9 && n < 40) begin
            drive(1'b0, 1'b0, 2'b01);
            n++;
        end
        check("rst_pos0_reached", 64'(pos[POS_W-1:0]), 64'd9);
        drive(1'b1, 1'b1, 2'b11);
        check("rst_state", 64'(state), 64'd0);
        check("rst_pos", 64'(pos), 64'd0);
        check("rst_speed", 64'(speed), 64'd0);

        // Randomised play.
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 19) == 0);
            if (m_state == 1) g = ($urandom_range(0, 15) == 0) ? NP'($urandom_range(1, 3)) : '0;
            else              g = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            drive(r, s, g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
